// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature decoder and its counter.
// Phase encoding is {A,B}; forward (A leads B) Gray order is 00 -> 10 -> 11 -> 01.
package qdec_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  // Direction encoding shared with the up/down counter's updown input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Next state in forward Gray order
  function automatic phase_t gray_next(input phase_t p);
    case (p)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  // Previous state in forward Gray order
  function automatic phase_t gray_prev(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Single-channel stable-for-N debounce. The output follows the input only
// after the input has differed from it for FILT_LEN consecutive cycles;
// any agreeing cycle discards the partial run.
module qdec_filter
  import qdec_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] LAST = 4'(FILT_LEN - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  // Count the run of disagreeing cycles and accept the new value on the last one
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (din != filt_q) begin
      if (cnt_q == LAST) begin
        filt_d = din;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises A/B, optionally debounces them,
// establishes a reference phase after reset, then emits one-cycle step strobes
// with a direction bit and a sticky error on two-bit phase jumps.
// Optional feature macro: QDEC_FILTER_EN (per-channel stable-for-FILT_LEN filters).
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   a_in,
  input  logic   b_in,
  input  logic   err_clr,
  output logic   step,
  output logic   updown,
  output logic   err,
  output logic   ready,
  output phase_t phase
);

  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("quad_decoder: FILT_LEN must be in 1..15");
  end

  logic   a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic   a_s1_d, a_s2_d, b_s1_d, b_s2_d;
  phase_t cur_ab;    // decoder's view of the encoder state
  phase_t prime_ab;  // value captured as reference when priming
  logic   prime_ok;  // reference may be taken this cycle

  // Two-flop synchroniser inputs
  always_comb begin
    a_s1_d = a_in;
    a_s2_d = a_s1_q;
    b_s1_d = b_in;
    b_s2_d = b_s1_q;
  end

  // Synchroniser registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1_q <= 1'b0;
      a_s2_q <= 1'b0;
      b_s1_q <= 1'b0;
      b_s2_q <= 1'b0;
    end else begin
      a_s1_q <= a_s1_d;
      a_s2_q <= a_s2_d;
      b_s1_q <= b_s1_d;
      b_s2_q <= b_s2_d;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam logic [3:0] START_LEN = 4'(FILT_LEN);

  logic       a_f, b_f;
  logic [3:0] start_cnt_q, start_cnt_d;

  qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a_s2_q),
    .dout (a_f)
  );

  qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b_s2_q),
    .dout (b_f)
  );

  // Saturating count of cycles since reset release; gates priming so a
  // channel that never changes still waits FILT_LEN cycles
  always_comb begin
    start_cnt_d = (start_cnt_q == START_LEN) ? start_cnt_q : start_cnt_q + 4'd1;
  end

  // Startup counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_cnt_q <= '0;
    else     start_cnt_q <= start_cnt_d;
  end

  // Prime only when nothing is in flight in either synchroniser or filter,
  // so the reference is the settled value and no change is pending
  assign cur_ab   = {a_f, b_f};
  assign prime_ab = cur_ab;
  assign prime_ok = (start_cnt_q == START_LEN) &&
                    (a_s1_q == a_f) && (a_s2_q == a_f) &&
                    (b_s1_q == b_f) && (b_s2_q == b_f);
`else
  logic start_q, start_d;

  // One-cycle startup delay after reset release
  always_comb begin
    start_d = 1'b1;
  end

  // Startup flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= 1'b0;
    else     start_q <= start_d;
  end

  // The reference is taken from the first stage: that is the value the
  // second stage holds after the priming edge, so no false change follows
  assign cur_ab   = {a_s2_q, b_s2_q};
  assign prime_ab = {a_s1_q, b_s1_q};
  assign prime_ok = start_q;
`endif

  logic   step_q, step_d;
  logic   updown_q, updown_d;
  logic   err_q, err_d;
  logic   ready_q, ready_d;
  phase_t phase_q, phase_d;

  // Priming and Gray-code decode; an illegal jump re-syncs phase and its set beats err_clr
  always_comb begin
    step_d   = 1'b0;
    updown_d = updown_q;
    err_d    = err_clr ? 1'b0 : err_q;
    ready_d  = ready_q;
    phase_d  = phase_q;
    if (!ready_q) begin
      if (prime_ok) begin
        ready_d = 1'b1;
        phase_d = prime_ab;
      end
    end else if (cur_ab != phase_q) begin
      phase_d = cur_ab;
      if (cur_ab == gray_next(phase_q)) begin
        step_d   = 1'b1;
        updown_d = DIR_UP;
      end else if (cur_ab == gray_prev(phase_q)) begin
        step_d   = 1'b1;
        updown_d = DIR_DOWN;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Registered decoder outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= 1'b0;
      updown_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      phase_q  <= PH_00;
    end else begin
      step_q   <= step_d;
      updown_q <= updown_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      phase_q  <= phase_d;
    end
  end

  assign step   = step_q;
  assign updown = updown_q;
  assign err    = err_q;
  assign ready  = ready_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: table of held input states with expected
// step count, direction, phase, error and a 4-bit counter fed by step/updown,
// plus hand-written priming, err_clr and mid-stream reset sequences.
module tb_quad_decoder;

  localparam int FL = 4;
`ifdef QDEC_FILTER_EN
  localparam int LAT        = FL + 2;
  localparam int PRIME_EDGE = FL + 2;
`else
  localparam int LAT        = 2;
  localparam int PRIME_EDGE = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, a_in, b_in, err_clr;
  logic       step, updown, err, ready;
  logic [1:0] phase;

  quad_decoder #(.FILT_LEN(FL)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .err_clr (err_clr),
    .step    (step),
    .updown  (updown),
    .err     (err),
    .ready   (ready),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Step monitor: sampled 1 time unit after each rising edge
  int   tot_steps = 0, tot_up = 0, tot_dn = 0, wide_cnt = 0;
  logic prev_step = 1'b0;
  always @(posedge clk) begin
    #1;
    if (step === 1'b1) begin
      tot_steps++;
      if (updown === 1'b1) tot_up++;
      else                 tot_dn++;
      if (prev_step === 1'b1) wide_cnt++;
    end
    prev_step = step;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Returns index of the first rising edge after which ready is high, -1 on timeout
  task automatic wait_ready(output int idx);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        idx = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         steps;
    logic       ud;
    logic [1:0] ph;
    logic       er;
    logic [3:0] cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin
    int         idx, s0, base_up, base_dn;
    logic [3:0] cnt_now;

    // Counter preset to 14 so the first two up steps also wrap 15 -> 0
    tbl[0]  = '{2'b01, 10, 1, 1'b1, 2'b01, 1'b0, 4'd15};
    tbl[1]  = '{2'b00, 10, 1, 1'b1, 2'b00, 1'b0, 4'd0};
    tbl[2]  = '{2'b10, 10, 1, 1'b1, 2'b10, 1'b0, 4'd1};
    tbl[3]  = '{2'b11, 10, 1, 1'b1, 2'b11, 1'b0, 4'd2};
    tbl[4]  = '{2'b01, 10, 1, 1'b1, 2'b01, 1'b0, 4'd3};
    tbl[5]  = '{2'b00, 10, 1, 1'b1, 2'b00, 1'b0, 4'd4};
    tbl[6]  = '{2'b01, 10, 1, 1'b0, 2'b01, 1'b0, 4'd3};
    tbl[7]  = '{2'b11, 10, 1, 1'b0, 2'b11, 1'b0, 4'd2};
    tbl[8]  = '{2'b10, 10, 1, 1'b0, 2'b10, 1'b0, 4'd1};
    tbl[9]  = '{2'b00, 10, 1, 1'b0, 2'b00, 1'b0, 4'd0};
    tbl[10] = '{2'b01, 10, 1, 1'b0, 2'b01, 1'b0, 4'd15};
    tbl[11] = '{2'b00, 10, 1, 1'b1, 2'b00, 1'b0, 4'd0};
`ifdef QDEC_FILTER_EN
    tbl[12] = '{2'b10,  3, 0, 1'b1, 2'b00, 1'b0, 4'd0};
    tbl[13] = '{2'b00, 10, 0, 1'b1, 2'b00, 1'b0, 4'd0};
    tbl[14] = '{2'b10,  6, 0, 1'b1, 2'b00, 1'b0, 4'd0};
    tbl[15] = '{2'b00, 10, 2, 1'b0, 2'b00, 1'b0, 4'd0};
`else
    tbl[12] = '{2'b10,  3, 1, 1'b1, 2'b10, 1'b0, 4'd1};
    tbl[13] = '{2'b00, 10, 1, 1'b0, 2'b00, 1'b0, 4'd0};
    tbl[14] = '{2'b10,  6, 1, 1'b1, 2'b10, 1'b0, 4'd1};
    tbl[15] = '{2'b00, 10, 1, 1'b0, 2'b00, 1'b0, 4'd0};
`endif
    tbl[16] = '{2'b11, 10, 0, 1'b0, 2'b11, 1'b1, 4'd0};

    // Reset with both phases high
    rst = 1'b1; a_in = 1'b1; b_in = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step",   step,   0);
    chk("rst_updown", updown, 0);
    chk("rst_err",    err,    0);
    chk("rst_ready",  ready,  0);
    chk("rst_phase",  phase,  0);

    // Priming
    s0  = tot_steps;
    rst = 1'b0;
    wait_ready(idx);
    chk("prime_edge",  idx,            PRIME_EDGE);
    chk("prime_phase", phase,          2'b11);
    chk("prime_err",   err,            0);
    repeat (3) @(negedge clk);
    chk("prime_steps", tot_steps - s0, 0);

    // Table of held states
    base_up = tot_up;
    base_dn = tot_dn;
    for (int i = 0; i < NV; i++) begin
      s0   = tot_steps;
      a_in = tbl[i].ab[1];
      b_in = tbl[i].ab[0];
      repeat (tbl[i].hold) @(negedge clk);
      cnt_now = 4'(14 + (tot_up - base_up) - (tot_dn - base_dn));
      chk($sformatf("r%0d_steps", i),  tot_steps - s0, tbl[i].steps);
      chk($sformatf("r%0d_updown", i), updown,         tbl[i].ud);
      chk($sformatf("r%0d_phase", i),  phase,          tbl[i].ph);
      chk($sformatf("r%0d_err", i),    err,            tbl[i].er);
      chk($sformatf("r%0d_count", i),  cnt_now,        tbl[i].cnt);
    end

    // Second illegal jump 11 -> 00 with err_clr in the very cycle it registers
    s0 = tot_steps;
    a_in = 1'b0; b_in = 1'b0;
    repeat (LAT) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("setwins_err",   err,            1);
    chk("setwins_phase", phase,          2'b00);
    chk("setwins_steps", tot_steps - s0, 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);

    // err_clr alone
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("errclr_err", err, 0);

    // Step up to 10, then reset mid-stream
    a_in = 1'b1; b_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_phase",  phase,  2'b10);
    chk("pre_rst_updown", updown, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_step",   step,   0);
    chk("midrst_updown", updown, 0);
    chk("midrst_err",    err,    0);
    chk("midrst_ready",  ready,  0);
    chk("midrst_phase",  phase,  0);
    repeat (2) @(negedge clk);

    // Re-priming with 10 held
    s0  = tot_steps;
    rst = 1'b0;
    wait_ready(idx);
    chk("reprime_edge",  idx,   PRIME_EDGE);
    chk("reprime_phase", phase, 2'b10);
    chk("reprime_err",   err,   0);
    repeat (10) @(negedge clk);
    chk("reprime_steps", tot_steps - s0, 0);
    chk("step_width",    wide_cnt,       0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
